// File: rtl/fp_unpack.sv
// fp_unpack: two-stage IEEE-754 unpacker producing {sign, exp, hid, frac, g, r, s}.
// S1 registers the operand fields and class flags; S2 forms the intermediate word.
// Optional build macro FP_UNPACK_DENORM_NORM_EN: normalizes denormal mantissas
// (shift left by lz+1, hid=1, o_lz reports the shift). Otherwise o_lz is tied to 0.
module fp_unpack #(
  parameter int WID    = 64,
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52,
  parameter int LZ_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [WID-1:0]    i,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [WID+3:0]    o,
  output logic [LZ_W-1:0]   o_lz,
  output logic              o_zero,
  output logic              o_inf,
  output logic              o_qnan,
  output logic              o_snan,
  output logic              o_dn
);

  logic              in_s;
  logic [EXP_W-1:0]  in_e;
  logic [FRAC_W-1:0] in_f;
  logic              e_ones, e_zero, f_nz;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_s_q;
  logic [EXP_W-1:0]  s1_e_q;
  logic [FRAC_W-1:0] s1_f_q;
  logic              s1_zero_q, s1_inf_q, s1_qnan_q, s1_snan_q, s1_dn_q;

  logic              o_valid_q, o_valid_d;
  logic [WID+3:0]    o_q, o_d;
  logic              o_zero_q, o_inf_q, o_qnan_q, o_snan_q, o_dn_q;
  logic [LZ_W-1:0]   lz_d;

  logic              hid;
  logic [FRAC_W-1:0] frac;
  logic              s2_free, s1_adv, accept;

  assign in_s   = i[WID-1];
  assign in_e   = i[WID-2 -: EXP_W];
  assign in_f   = i[FRAC_W-1:0];
  assign e_ones = &in_e;
  assign e_zero = ~|in_e;
  assign f_nz   = |in_f;

  // S2 can take new data when empty or when its word leaves this cycle.
  assign s2_free = !o_valid_q | o_ready;
  assign s1_adv  = s1_valid_q & s2_free;
  assign i_ready = !s1_valid_q | s1_adv;
  assign accept  = i_valid & i_ready;

  assign s1_valid_d = accept ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
  assign o_valid_d  = s1_adv ? 1'b1 : (o_ready ? 1'b0 : o_valid_q);

`ifdef FP_UNPACK_DENORM_NORM_EN
  logic [LZ_W-1:0] lz_in, s1_lz_q, lz_p1, o_lz_q;

  // Leading-zero count of the incoming fraction (FRAC_W when all zero).
  always_comb begin
    lz_in = LZ_W'(FRAC_W);
    for (int unsigned b = 0; b < FRAC_W; b++) begin
      if (in_f[b]) lz_in = LZ_W'(FRAC_W - 1 - b);
    end
  end

  assign lz_p1 = s1_lz_q + LZ_W'(1);

  // Leading-zero register travels alongside the S1 operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         s1_lz_q <= '0;
    else if (accept) s1_lz_q <= lz_in;
  end

  // Shift amount register for the S2 word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         o_lz_q <= '0;
    else if (s1_adv) o_lz_q <= lz_d;
  end

  assign o_lz = o_lz_q;
`else
  assign o_lz = '0;
`endif

  // S1: capture fields and classify the accepted operand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_e_q     <= '0;
      s1_f_q     <= '0;
      s1_zero_q  <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_qnan_q  <= 1'b0;
      s1_snan_q  <= 1'b0;
      s1_dn_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_s_q    <= in_s;
        s1_e_q    <= in_e;
        s1_f_q    <= in_f;
        s1_zero_q <= e_zero & !f_nz;
        s1_inf_q  <= e_ones & !f_nz;
        s1_qnan_q <= e_ones & in_f[FRAC_W-1];
        s1_snan_q <= e_ones & f_nz & !in_f[FRAC_W-1];
        s1_dn_q   <= e_zero & f_nz;
      end
    end
  end

  // S2 word formation: hidden bit from exponent, optional denormal normalization.
  always_comb begin
    hid  = |s1_e_q;
    frac = s1_f_q;
    lz_d = '0;
`ifdef FP_UNPACK_DENORM_NORM_EN
    if (s1_dn_q) begin
      frac = s1_f_q << lz_p1;
      hid  = 1'b1;
      lz_d = lz_p1;
    end
`endif
    o_d = {s1_s_q, s1_e_q, hid, frac, 3'b000};
  end

  // S2: output register, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_q       <= '0;
      o_zero_q  <= 1'b0;
      o_inf_q   <= 1'b0;
      o_qnan_q  <= 1'b0;
      o_snan_q  <= 1'b0;
      o_dn_q    <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      if (s1_adv) begin
        o_q      <= o_d;
        o_zero_q <= s1_zero_q;
        o_inf_q  <= s1_inf_q;
        o_qnan_q <= s1_qnan_q;
        o_snan_q <= s1_snan_q;
        o_dn_q   <= s1_dn_q;
      end
    end
  end

  assign o_valid = o_valid_q;
  assign o       = o_q;
  assign o_zero  = o_zero_q;
  assign o_inf   = o_inf_q;
  assign o_qnan  = o_qnan_q;
  assign o_snan  = o_snan_q;
  assign o_dn    = o_dn_q;

endmodule

// File: tb/tb_fp_unpack.sv
// Directed bench for fp_unpack: vector table, streaming with backpressure,
// full-rate streaming and reset with both stages occupied.
// Expected values follow FP_UNPACK_DENORM_NORM_EN when the bench is built with it.
module tb_fp_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [63:0] i;
  logic        o_valid;
  logic        o_ready;
  logic [67:0] o;
  logic [5:0]  o_lz;
  logic        o_zero, o_inf, o_qnan, o_snan, o_dn;

  int checks = 0;
  int errors = 0;

  fp_unpack #(.WID(64), .EXP_W(11), .FRAC_W(52), .LZ_W(6)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i(i),
    .o_valid(o_valid), .o_ready(o_ready), .o(o), .o_lz(o_lz),
    .o_zero(o_zero), .o_inf(o_inf), .o_qnan(o_qnan), .o_snan(o_snan), .o_dn(o_dn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] in;
    logic [67:0] o;
    logic [5:0]  lz;
    logic [4:0]  fl;   // {zero, inf, qnan, snan, dn}
  } vec_t;

  vec_t vt[11];

  function automatic logic [67:0] mk(input logic s, input logic [10:0] e,
                                     input logic h, input logic [51:0] f);
    return {s, e, h, f, 3'b000};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] stream_op(input int k);
    return {12'h3FF, 52'(k * 3 + 1)};
  endfunction

  function automatic logic [67:0] stream_exp(input int k);
    return mk(1'b0, 11'h3FF, 1'b1, 52'(k * 3 + 1));
  endfunction

  task automatic send_one(input logic [63:0] op, output logic [67:0] oo,
                          output logic [5:0] lzo, output logic [4:0] flo, output int lat);
    @(negedge clk);
    i = op; i_valid = 1'b1; o_ready = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (o_valid) begin lat = k; break; end
    end
    oo  = o;
    lzo = o_lz;
    flo = {o_zero, o_inf, o_qnan, o_snan, o_dn};
  endtask

  task automatic stream(input int n, input int slo, input int shi, input bit tp);
    int sent, rcvd;
    logic [67:0] held;
    bit have_held;
    sent = 0; rcvd = 0; have_held = 1'b0; held = '0;
    for (int c = 0; c < 60 && rcvd < n; c++) begin
      @(negedge clk);
      o_ready = !(c >= slo && c <= shi);
      i_valid = (sent < n);
      i = stream_op(sent);
      #1;
      if (have_held) begin
        check("hold_valid", o_valid, 1'b1);
        check("hold_o", o, held);
        have_held = 1'b0;
      end
      if (slo >= 0 && (c == slo + 1 || c == slo + 2)) check("stall_i_ready", i_ready, 1'b0);
      if (o_valid && o_ready) begin
        check("stream_o", o, stream_exp(rcvd));
        if (tp) check("stream_cycle", c, rcvd + 2);
        rcvd++;
      end else if (o_valid) begin
        held = o; have_held = 1'b1;
      end
      if (i_valid && i_ready) sent++;
      @(posedge clk);
    end
    #1 i_valid = 1'b0; o_ready = 1'b1;
    check("stream_count", rcvd, n);
    @(negedge clk);
    check("stream_drained", o_valid, 1'b0);
  endtask

  initial begin
    logic [67:0] oo;
    logic [5:0]  lzo;
    logic [4:0]  flo;
    int lat;

    vt[0]  = '{64'h3FF0000000000000, mk(0, 11'h3FF, 1, 52'h0), 6'd0, 5'b00000};
`ifdef FP_UNPACK_DENORM_NORM_EN
    vt[1]  = '{64'h0000000000000001, mk(0, 11'h000, 1, 52'h0), 6'd52, 5'b00001};
    vt[6]  = '{64'h0008000000000000, mk(0, 11'h000, 1, 52'h0), 6'd1, 5'b00001};
    vt[8]  = '{64'h800000000000F000, mk(1, 11'h000, 1, 52'hE000000000000), 6'd37, 5'b00001};
`else
    vt[1]  = '{64'h0000000000000001, mk(0, 11'h000, 0, 52'h1), 6'd0, 5'b00001};
    vt[6]  = '{64'h0008000000000000, mk(0, 11'h000, 0, 52'h8000000000000), 6'd0, 5'b00001};
    vt[8]  = '{64'h800000000000F000, mk(1, 11'h000, 0, 52'h000000000F000), 6'd0, 5'b00001};
`endif
    vt[2]  = '{64'hFFF0000000000000, mk(1, 11'h7FF, 1, 52'h0), 6'd0, 5'b01000};
    vt[3]  = '{64'h7FF0000000000001, mk(0, 11'h7FF, 1, 52'h1), 6'd0, 5'b00010};
    vt[4]  = '{64'h7FF8000000000000, mk(0, 11'h7FF, 1, 52'h8000000000000), 6'd0, 5'b00100};
    vt[5]  = '{64'h8000000000000000, mk(1, 11'h000, 0, 52'h0), 6'd0, 5'b10000};
    vt[7]  = '{64'hC000000000000000, mk(1, 11'h400, 1, 52'h0), 6'd0, 5'b00000};
    vt[9]  = '{64'h7FFFFFFFFFFFFFFF, mk(0, 11'h7FF, 1, 52'hFFFFFFFFFFFFF), 6'd0, 5'b00100};
    vt[10] = '{64'h3FF8000000000001, mk(0, 11'h3FF, 1, 52'h8000000000001), 6'd0, 5'b00000};

    rst = 1'b1; i_valid = 1'b0; i = '0; o_ready = 1'b1;
    #3;
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o", o, '0);
    check("rst_lz", o_lz, '0);
    check("rst_flags", {o_zero, o_inf, o_qnan, o_snan, o_dn}, 5'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 check("rst_i_ready", i_ready, 1'b1);

    // Table of single operands, each sent into an empty pipe.
    for (int v = 0; v < 11; v++) begin
      send_one(vt[v].in, oo, lzo, flo, lat);
      check($sformatf("lat_%0d", v), lat, 2);
      check($sformatf("o_%0d", v), oo, vt[v].o);
      check($sformatf("lz_%0d", v), lzo, vt[v].lz);
      check($sformatf("flags_%0d", v), flo, vt[v].fl);
    end

    // 8 operands with downstream stalled on cycles 3..6.
    stream(8, 3, 6, 1'b0);
    // Continuous valid/ready: one result per cycle after a 2-cycle fill.
    stream(10, -1, -2, 1'b1);

    // Reset with both stages occupied.
    @(negedge clk);
    o_ready = 1'b0; i_valid = 1'b1; i = stream_op(20);
    @(posedge clk);
    @(negedge clk) i = stream_op(21);
    @(posedge clk);
    @(negedge clk) i_valid = 1'b0;
    #1;
    check("full_o_valid", o_valid, 1'b1);
    check("full_i_ready", i_ready, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_o_valid", o_valid, 1'b0);
    check("midrst_o", o, '0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 check("postrst_i_ready", i_ready, 1'b1);
    check("postrst_o_valid", o_valid, 1'b0);
    send_one(vt[0].in, oo, lzo, flo, lat);
    check("postrst_lat", lat, 2);
    check("postrst_o", oo, vt[0].o);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
